// File: rtl/servo_sweep_sched_if.sv
// Manual-request handshake between a position source and the servo scheduler.
interface servo_sweep_sched_if;
  logic       man_valid;
  logic [2:0] man_speed;
  logic       man_ready;

  // Request source drives valid/code and observes ready.
  modport master (
    output man_valid,
    output man_speed,
    input  man_ready
  );

  // Scheduler consumes valid/code and drives ready.
  modport slave (
    input  man_valid,
    input  man_speed,
    output man_ready
  );
endinterface

// File: rtl/servo_sweep_sched.sv
// Frame-synchronous speed/position scheduler for the servo PWM generator.
// Owns the tick prescaler and PWM frame counter; manual or sweep mode, with
// every code change landing on a frame boundary.
module servo_sweep_sched #(
  parameter int unsigned CLK_DIV     = 25000,
  parameter int unsigned FRAME_TICKS = 80,
  parameter int unsigned HOLD_FRAMES = 10,
  parameter int unsigned SPEED_MIN   = 0,
  parameter int unsigned SPEED_MAX   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  servo_sweep_sched_if.slave   man_if,
  output logic [2:0]           speed,
  output logic                 frame_start,
  output logic                 dir,
  output logic                 busy
);

  localparam int unsigned SPEED_W = 3;
  localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [SPEED_W-1:0] MIN_S = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(SPEED_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SWEEP  = 2'd2
  } state_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic               frame_start_q, frame_start_d;
  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               dir_q, dir_d;
  logic               pend_valid_q, pend_valid_d;
  logic [SPEED_W-1:0] pend_speed_q, pend_speed_d;
  logic               man_ready_q, man_ready_d;
  logic               busy_q, busy_d;

  logic               tick_c;
  logic               xfer_c;
  logic               step_up_c;
  logic [SPEED_W-1:0] step_speed_c;
  logic [SPEED_W-1:0] clamp_speed_c;

  // Prescaler and frame counter; free-running in every state.
  always_comb begin
    tick_c        = (presc_q == PRESC_W'(CLK_DIV - 1));
    presc_d       = tick_c ? '0 : PRESC_W'(presc_q + PRESC_W'(1));
    tick_cnt_d    = tick_cnt_q;
    frame_start_d = 1'b0;
    if (tick_c) begin
      if (tick_cnt_q == TICK_W'(FRAME_TICKS - 1)) begin
        tick_cnt_d    = '0;
        frame_start_d = 1'b1;
      end else begin
        tick_cnt_d = TICK_W'(tick_cnt_q + TICK_W'(1));
      end
    end
  end

  // Clamp to the sweep bounds and compute the next sweep step.
  always_comb begin
    clamp_speed_c = speed_q;
    if (32'(speed_q) < SPEED_MIN) begin
      clamp_speed_c = MIN_S;
    end else if (32'(speed_q) > SPEED_MAX) begin
      clamp_speed_c = MAX_S;
    end
    // Turn around at an endpoint even if dir disagrees (e.g. entering at a bound).
    if (dir_q) begin
      step_up_c = (32'(speed_q) < SPEED_MAX);
    end else begin
      step_up_c = (32'(speed_q) <= SPEED_MIN);
    end
    step_speed_c = step_up_c ? SPEED_W'(speed_q + SPEED_W'(1))
                             : SPEED_W'(speed_q - SPEED_W'(1));
  end

  // Mode FSM, request capture and frame-boundary code updates.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    speed_d      = speed_q;
    dir_d        = dir_q;
    pend_valid_d = pend_valid_q;
    pend_speed_d = pend_speed_q;

    xfer_c = man_if.man_valid && man_ready_q;
    if (xfer_c) begin
      pend_valid_d = 1'b1;
      pend_speed_d = man_if.man_speed;
    end

    if (frame_start_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            hold_d = '0;
            if (mode) begin
              state_d = ST_SWEEP;
              speed_d = clamp_speed_c;
            end else begin
              state_d = ST_MANUAL;
            end
          end
        end
        ST_MANUAL: begin
          if (!enable) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
          end else if (mode) begin
            state_d      = ST_SWEEP;
            hold_d       = '0;
            speed_d      = clamp_speed_c;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            // A request captured in this same cycle waits for the next boundary.
            speed_d      = pend_speed_q;
            pend_valid_d = 1'b0;
          end
        end
        ST_SWEEP: begin
          if (!enable) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (!mode) begin
            state_d = ST_MANUAL;
            hold_d  = '0;
          end else if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
            hold_d  = '0;
            speed_d = step_speed_c;
            if (step_speed_c == MAX_S) begin
              dir_d = 1'b0;
            end else if (step_speed_c == MIN_S) begin
              dir_d = 1'b1;
            end
          end else begin
            hold_d = HOLD_W'(hold_q + HOLD_W'(1));
          end
        end
        default: begin
          state_d      = ST_IDLE;
          pend_valid_d = 1'b0;
        end
      endcase
    end

    man_ready_d = (state_d == ST_MANUAL) && !pend_valid_d;
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      tick_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      speed_q       <= MIN_S;
      dir_q         <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_speed_q  <= '0;
      man_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      tick_cnt_q    <= tick_cnt_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
      hold_q        <= hold_d;
      speed_q       <= speed_d;
      dir_q         <= dir_d;
      pend_valid_q  <= pend_valid_d;
      pend_speed_q  <= pend_speed_d;
      man_ready_q   <= man_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign man_if.man_ready = man_ready_q;
  assign speed            = speed_q;
  assign frame_start      = frame_start_q;
  assign dir              = dir_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_servo_sweep_sched.sv
// Self-checking bench for servo_sweep_sched: instance A (bounds 0..7) covers
// reset/frame timing and the manual handshake; instance B (bounds 1..3,
// 2-frame hold) covers sweep ping-pong and disable.
module tb_servo_sweep_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_a = 1'b0, mode_a = 1'b0;
  logic enable_b = 1'b0, mode_b = 1'b0;
  logic [2:0] speed_a, speed_b;
  logic fs_a, fs_b, dir_a, dir_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  servo_sweep_sched_if if_a();
  servo_sweep_sched_if if_b();

  always #5 clk = ~clk;

  servo_sweep_sched #(
    .CLK_DIV(4), .FRAME_TICKS(8), .HOLD_FRAMES(2), .SPEED_MIN(0), .SPEED_MAX(7)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .mode(mode_a), .man_if(if_a.slave),
    .speed(speed_a), .frame_start(fs_a), .dir(dir_a), .busy(busy_a)
  );

  servo_sweep_sched #(
    .CLK_DIV(4), .FRAME_TICKS(8), .HOLD_FRAMES(2), .SPEED_MIN(1), .SPEED_MAX(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .mode(mode_b), .man_if(if_b.slave),
    .speed(speed_b), .frame_start(fs_b), .dir(dir_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected instance shows frame_start; n = edges taken.
  task automatic wait_fs(input bit sel, output int n);
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (!(sel ? fs_b : fs_a) && n < 100);
    if (!(sel ? fs_b : fs_a)) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  // Wait for the next boundary, then compare speed/dir against the scoreboard.
  task automatic frame_check(input bit sel, input string tag);
    int n;
    logic [3:0] e;
    wait_fs(sel, n);
    tick_clk();
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_speed"}, 32'(sel ? speed_b : speed_a), 32'(e[2:0]));
      chk({tag, "_dir"},   32'(sel ? dir_b : dir_a),     32'(e[3]));
    end
  endtask

  initial begin
    int n;
    if_a.man_valid = 1'b0; if_a.man_speed = 3'd0;
    if_b.man_valid = 1'b0; if_b.man_speed = 3'd0;

    // 1. Reset and frame timing
    repeat (3) tick_clk();
    rst_n = 1'b1;
    chk("rst_speed", 32'(speed_a), 32'd0);
    chk("rst_dir", 32'(dir_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(if_a.man_ready), 32'd0);
    chk("rst_fs", 32'(fs_a), 32'd0);
    chk("rst_speed_b", 32'(speed_b), 32'd1);
    wait_fs(1'b0, n);
    chk("first_fs_lat", 32'(n), 32'd32);
    tick_clk();
    chk("fs_width", 32'(fs_a), 32'd0);
    wait_fs(1'b0, n);
    chk("fs_period", 32'(n + 1), 32'd32);

    // 2. Manual handshake
    tick_clk();
    enable_a = 1'b1; mode_a = 1'b0;
    wait_fs(1'b0, n);
    tick_clk();
    chk("man_busy", 32'(busy_a), 32'd1);
    chk("man_ready_up", 32'(if_a.man_ready), 32'd1);
    repeat (10) tick_clk();
    if_a.man_valid = 1'b1; if_a.man_speed = 3'd5;
    tick_clk();
    if_a.man_valid = 1'b0;
    chk("man_ready_drop", 32'(if_a.man_ready), 32'd0);
    chk("man_speed_held", 32'(speed_a), 32'd0);
    exp_q.push_back({1'b1, 3'd5});
    frame_check(1'b0, "man5");
    chk("man_ready_back", 32'(if_a.man_ready), 32'd1);

    // 3. Transfer in the frame_start cycle applies one frame later
    wait_fs(1'b0, n);
    if_a.man_valid = 1'b1; if_a.man_speed = 3'd3;
    tick_clk();
    if_a.man_valid = 1'b0;
    chk("simul_speed_unch", 32'(speed_a), 32'd5);
    chk("simul_ready_drop", 32'(if_a.man_ready), 32'd0);
    exp_q.push_back({1'b1, 3'd3});
    frame_check(1'b0, "simul3");
    chk("simul_ready_back", 32'(if_a.man_ready), 32'd1);

    // 6. Reset mid-operation drops the pending request
    repeat (5) tick_clk();
    if_a.man_valid = 1'b1; if_a.man_speed = 3'd6;
    tick_clk();
    if_a.man_valid = 1'b0;
    chk("pend_ready_drop", 32'(if_a.man_ready), 32'd0);
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    chk("rst2_speed", 32'(speed_a), 32'd0);
    chk("rst2_ready", 32'(if_a.man_ready), 32'd0);
    chk("rst2_busy", 32'(busy_a), 32'd0);
    wait_fs(1'b0, n);
    chk("rst2_fs_lat", 32'(n), 32'd32);
    tick_clk();
    chk("rst2_pend_lost", 32'(speed_a), 32'd0);
    chk("rst2_ready_up", 32'(if_a.man_ready), 32'd1);
    enable_a = 1'b0;

    // 4. Sweep ping-pong on instance B, entered from out-of-range speed 0
    enable_b = 1'b1; mode_b = 1'b0;
    wait_fs(1'b1, n);
    tick_clk();
    chk("b_man_ready", 32'(if_b.man_ready), 32'd1);
    repeat (8) tick_clk();
    if_b.man_valid = 1'b1; if_b.man_speed = 3'd0;
    tick_clk();
    if_b.man_valid = 1'b0;
    exp_q.push_back({1'b1, 3'd0});
    frame_check(1'b1, "b_man0_noclamp");
    mode_b = 1'b1;
    exp_q.push_back({1'b1, 3'd1});
    frame_check(1'b1, "b_entry_clamp");
    chk("b_sweep_busy", 32'(busy_b), 32'd1);
    chk("b_sweep_ready", 32'(if_b.man_ready), 32'd0);
    exp_q.push_back({1'b1, 3'd1});
    exp_q.push_back({1'b1, 3'd2});
    exp_q.push_back({1'b1, 3'd2});
    exp_q.push_back({1'b0, 3'd3});
    exp_q.push_back({1'b0, 3'd3});
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b1, 3'd1});
    exp_q.push_back({1'b1, 3'd1});
    exp_q.push_back({1'b1, 3'd2});
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) frame_check(1'b1, "b_sweep");
    chk("b_sb_drained", 32'(exp_q.size()), 32'd0);

    // 5. Disable mid-frame: stays SWEEP until boundary, then IDLE holding 2
    repeat (10) tick_clk();
    enable_b = 1'b0;
    tick_clk();
    chk("dis_still_busy", 32'(busy_b), 32'd1);
    exp_q.push_back({1'b1, 3'd2});
    frame_check(1'b1, "dis_idle");
    chk("dis_busy", 32'(busy_b), 32'd0);
    chk("dis_ready", 32'(if_b.man_ready), 32'd0);
    exp_q.push_back({1'b1, 3'd2});
    frame_check(1'b1, "dis_hold");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_sweep_sched.md
Name: servo_sweep_sched

Overview:
- Frame-synchronous scheduler that produces the 3-bit speed/position code for the servo PWM generator.
- Owns the 2 kHz tick prescaler and the 80-tick PWM frame counter.
- Operates in two modes. In manual mode it accepts single position requests over a valid/ready handshake. In sweep mode it autonomously steps the code between bounds.
- Code changes are applied only at frame boundaries, so no PWM pulse is ever truncated.

Parameters:
- CLK_DIV, 25000, clk cycles per tick (50 MHz gives a 2 kHz tick).
- FRAME_TICKS, 80, ticks per PWM frame.
- HOLD_FRAMES, 10, frames dwelt at each sweep position (must be ≥1).
- SPEED_MIN, 0, lower sweep bound (3-bit).
- SPEED_MAX, 7, upper sweep bound (3-bit, must be > SPEED_MIN).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; synchronous, active-low.
- enable, input, 1, 1 = run; 0 = go idle at the next frame boundary.
- mode, input, 1, 0 = manual, 1 = sweep; sampled only at frame_start.
- man_valid, input, 1, manual request valid.
- man_speed, input, 3, manual requested code.
- man_ready, output, 1, scheduler can accept a manual request.
- speed, output, 3, code to the PWM generator (registered).
- frame_start, output, 1, one-clk pulse at each frame boundary.
- dir, output, 1, sweep direction (1 = up).
- busy, output, 1, 1 in the MANUAL or SWEEP states.

Behaviour:
- Reset (rst_n = 0 at a clk edge) forces the following values:
  - Counters: prescaler = 0, tick counter = 0, hold counter = 0.
  - State: IDLE. The pending-request register is cleared.
  - Outputs: speed = SPEED_MIN, dir = 1, frame_start = 0, man_ready = 0, busy = 0.
  - Reset mid-operation discards any pending request.
- Prescaler:
  - Counts 0 to CLK_DIV-1 and wraps.
  - tick is internal, high for one clk when the prescaler equals CLK_DIV-1.
- Frame counter:
  - Advances on tick, counting 0 to FRAME_TICKS-1.
  - frame_start is registered: it is high for the one clk after the cycle in which both tick = 1 and the frame count = FRAME_TICKS-1.
  - The first frame_start occurs CLK_DIV*FRAME_TICKS clks after reset release.
  - The prescaler and frame counter run in every state.
- All state transitions, mode sampling and speed updates occur only in a cycle where frame_start = 1. The new speed is visible on the next clk.
- IDLE:
  - speed holds its last value; man_ready = 0; busy = 0.
  - At frame_start with enable = 1: mode = 0 goes to MANUAL, mode = 1 goes to SWEEP.
- MANUAL:
  - man_ready = 1 whenever no request is pending.
  - A transfer occurs when man_valid && man_ready. It latches man_speed into the pending register, and man_ready drops on the next clk.
  - At frame_start with a request pending: speed ← pending value, pending is cleared, and man_ready reasserts on the next clk.
  - A transfer in the same cycle as frame_start is not applied at that boundary; it applies at the following one.
  - Manual values outside [SPEED_MIN, SPEED_MAX] are applied unchanged (no clamping).
- SWEEP:
  - man_ready = 0.
  - At each frame_start, the hold counter increments.
  - When the hold counter reaches HOLD_FRAMES-1, it clears and speed steps by ±1 according to dir.
  - If the step lands on SPEED_MAX, dir ← 0. If it lands on SPEED_MIN, dir ← 1.
  - The sequence therefore ping-pongs with no repeated endpoint beyond HOLD_FRAMES.
  - On entry to SWEEP, if speed is outside the bounds it is clamped to the nearest bound at the entry boundary, and the hold counter is cleared.
- Leaving MANUAL or SWEEP:
  - At frame_start with enable = 0: go to IDLE, speed holds, and any pending request is dropped.
  - A change of mode at frame_start switches directly between MANUAL and SWEEP. The hold counter clears and dir is retained.
- busy = 1 exactly in the MANUAL and SWEEP states.

Test Plan:
All scenarios use CLK_DIV = 4 and FRAME_TICKS = 8 (32 clk per frame).
1. Reset and frame timing: hold rst_n = 0 for 3 clk, then release → speed = 0, dir = 1, busy = 0. First frame_start is exactly 32 clk after release, then one every 32 clk, each 1 clk wide.
2. Manual handshake: set enable = 1, mode = 0 and wait for MANUAL. Drive man_valid with man_speed = 5 mid-frame → man_ready drops the next clk. At the next frame_start, speed = 5 on the following clk and man_ready returns to 1.
3. Simultaneous event: assert man_valid with man_speed = 3 in the exact frame_start cycle → speed is unchanged at that boundary and becomes 3 at the next frame_start.
4. Sweep ping-pong: use HOLD_FRAMES = 2, SPEED_MIN = 1, SPEED_MAX = 3 and start with speed = 0 → clamped to 1 at entry. The speed sequence is then 1, 2, 3, 2, 1, 2, changing every 2 frames. dir = 0 after reaching 3 and dir = 1 after reaching 1.
5. Disable mid-sweep: drop enable mid-frame with speed = 2 → the state stays SWEEP until the next frame_start, then goes IDLE with busy = 0 and speed holding at 2.
6. Reset mid-operation: with a request pending in MANUAL, pulse rst_n low → speed = SPEED_MIN, the pending request is lost, man_ready = 0, and the counters restart from 0.
